// File: rtl/gate_chk_pkg.sv
// Shared encodings for the gate response checker: reference-function ops, FSM states
// and the settle counter width.
package gate_chk_pkg;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  // Wide enough for the largest legal settle time (15 cycles).
  localparam int unsigned SettleCntW = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StApply  = 2'b01,
    StSample = 2'b10,
    StDone   = 2'b11
  } state_e;

endpackage

// File: rtl/gate_resp_checker_if.sv
// Stimulus/response bundle between the checker (master) and the gate-under-test
// environment (slave).
interface gate_resp_checker_if #(
  parameter int unsigned N_IN = 2
) ();

  logic            start;
  logic [1:0]      op;
  logic            dut_y;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] fail_vec;
  logic            fail_valid;

  modport master (
    input  start,
    input  op,
    input  dut_y,
    output vec,
    output busy,
    output done,
    output pass,
    output err_cnt,
    output fail_vec,
    output fail_valid
  );

  modport slave (
    output start,
    output op,
    output dut_y,
    input  vec,
    input  busy,
    input  done,
    input  pass,
    input  err_cnt,
    input  fail_vec,
    input  fail_valid
  );

endinterface

// File: rtl/gate_ref_model.sv
// Combinational reference gate: expected output for a given op and input vector.
module gate_ref_model
  import gate_chk_pkg::*;
#(
  parameter int unsigned N_IN = 2
) (
  input  logic [1:0]      op_i,
  input  logic [N_IN-1:0] vec_i,
  output logic            expected_o
);

  always_comb begin
    expected_o = 1'b0;
    unique case (op_i)
      OP_OR:   expected_o = |vec_i;
      OP_AND:  expected_o = &vec_i;
      OP_XOR:  expected_o = ^vec_i;
      OP_NOR:  expected_o = ~|vec_i;
      default: expected_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_resp_checker.sv
// Exhaustive on-chip checker for an N-input combinational gate: sweeps all vectors,
// samples the gate after a settle time and records error count and first failure.
module gate_resp_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  gate_resp_checker_if.master bus
);

  localparam logic [N_IN-1:0]       VecMax     = '1;
  localparam logic [SettleCntW-1:0] SettleLast = SettleCntW'(SETTLE - 1);

  state_e                state_q, state_d;
  logic [N_IN-1:0]       vec_q, vec_d;
  logic [SettleCntW-1:0] cnt_q, cnt_d;
  logic [1:0]            op_q, op_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [N_IN:0]         err_q, err_d;
  logic [N_IN-1:0]       fail_vec_q, fail_vec_d;
  logic                  fail_valid_q, fail_valid_d;

  logic expected;
  logic mismatch;

  gate_ref_model #(
    .N_IN(N_IN)
  ) u_ref (
    .op_i      (op_q),
    .vec_i     (vec_q),
    .expected_o(expected)
  );

  assign mismatch = (bus.dut_y != expected);

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_vec_d   = fail_vec_q;
    fail_valid_d = fail_valid_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d      = StApply;
          op_d         = bus.op;
          vec_d        = '0;
          cnt_d        = '0;
          err_d        = '0;
          fail_vec_d   = '0;
          fail_valid_d = 1'b0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
        end
      end
      StApply: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + SettleCntW'(1);
        end
      end
      StSample: begin
        if (mismatch) begin
          err_d = err_q + (N_IN + 1)'(1);
          if (!fail_valid_q) begin
            fail_vec_d   = vec_q;
            fail_valid_d = 1'b1;
          end
        end
        if (vec_q == VecMax) begin
          // pass/done are registered, so they go high together on entry to DONE.
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          vec_d   = vec_q + N_IN'(1);
          state_d = StApply;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      vec_q        <= '0;
      cnt_q        <= '0;
      op_q         <= OP_OR;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_vec_q   <= fail_vec_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  assign bus.vec        = vec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err_q;
  assign bus.fail_vec   = fail_vec_q;
  assign bus.fail_valid = fail_valid_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Bench for gate_resp_checker: table-driven and random runs on a 2-input instance,
// plus two 3-input instances driving a gate whose output lags its inputs by 2 cycles.
module tb_gate_resp_checker;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gate_resp_checker_if #(.N_IN(2)) if_a ();
  gate_resp_checker_if #(.N_IN(3)) if_b ();
  gate_resp_checker_if #(.N_IN(3)) if_c ();

  gate_resp_checker #(.N_IN(2), .SETTLE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  gate_resp_checker #(.N_IN(3), .SETTLE(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  gate_resp_checker #(.N_IN(3), .SETTLE(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  // Instance A's gate is an arbitrary truth table; bit v is the output for vector v.
  logic [3:0] tt_a;
  assign if_a.dut_y = tt_a[if_a.vec];

  // Instances B and C see an OR gate whose output arrives 2 cycles late.
  logic b_d1, b_d2, c_d1, c_d2;
  always @(posedge clk) begin
    b_d1 <= |if_b.vec;
    b_d2 <= b_d1;
    c_d1 <= |if_c.vec;
    c_d2 <= c_d1;
  end
  assign if_b.dut_y = b_d2;
  assign if_c.dut_y = c_d2;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference functions computed from the population count of the vector.
  function automatic bit ref_f(input logic [1:0] op, input int v, input int n);
    int ones;
    ones = $countones(v);
    case (op)
      2'd0:    return ones != 0;
      2'd1:    return ones == n;
      2'd2:    return (ones % 2) == 1;
      default: return ones == 0;
    endcase
  endfunction

  // One full run on instance A: checks the vector sweep, busy, done timing and results.
  task automatic run_a(input string tag, input logic [1:0] op, input logic [3:0] tt,
                       input bit poke, input int e_err, input int e_fv, input bit e_valid);
    int seq_bad = 0;
    int done_at = -1;
    tt_a = tt;
    @(negedge clk);
    if_a.op    = op;
    if_a.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        if (if_a.vec !== 2'((k - 1) / 2) || if_a.busy !== 1'b1 || if_a.done !== 1'b0)
          seq_bad++;
      end else if (k == 9) begin
        if (if_a.vec !== 2'd3 || if_a.busy !== 1'b0) seq_bad++;
      end else begin
        if (if_a.busy !== 1'b0 || if_a.done !== 1'b0) seq_bad++;
      end
      if (if_a.done === 1'b1 && done_at < 0) done_at = k;
      if (k == 1) if_a.start = 1'b0;
      if (poke && k == 5) begin
        if_a.start = 1'b1;
        if_a.op    = ~op;
      end
      if (poke && k == 6) if_a.start = 1'b0;
    end
    chk($sformatf("%s seq", tag), seq_bad, 0);
    chk($sformatf("%s done_at", tag), done_at, 9);
    chk($sformatf("%s err_cnt", tag), if_a.err_cnt, e_err);
    chk($sformatf("%s fail_vec", tag), if_a.fail_vec, e_fv);
    chk($sformatf("%s fail_valid", tag), if_a.fail_valid, e_valid);
    chk($sformatf("%s pass", tag), if_a.pass, (e_err == 0));
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] tt;
    bit         poke;
    int         err;
    int         fv;
    bit         valid;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int   b_done, c_done, c_err, c_fv;

    tbl[0] = '{op: 2'b00, tt: 4'b1110, poke: 1'b0, err: 0, fv: 0, valid: 1'b0};
    tbl[1] = '{op: 2'b00, tt: 4'b0000, poke: 1'b0, err: 3, fv: 1, valid: 1'b1};
    tbl[2] = '{op: 2'b01, tt: 4'b1110, poke: 1'b0, err: 2, fv: 1, valid: 1'b1};
    tbl[3] = '{op: 2'b11, tt: 4'b1110, poke: 1'b0, err: 4, fv: 0, valid: 1'b1};
    tbl[4] = '{op: 2'b00, tt: 4'b1110, poke: 1'b1, err: 0, fv: 0, valid: 1'b0};
    tbl[5] = '{op: 2'b10, tt: 4'b1110, poke: 1'b0, err: 1, fv: 3, valid: 1'b1};
    tbl[6] = '{op: 2'b01, tt: 4'b1000, poke: 1'b0, err: 0, fv: 0, valid: 1'b0};

    rst_n = 1'b0;
    tt_a  = 4'b1110;
    if_a.start = 1'b0; if_a.op = 2'b00;
    if_b.start = 1'b0; if_b.op = 2'b00;
    if_c.start = 1'b0; if_c.op = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst vec", if_a.vec, 0);
    chk("rst busy", if_a.busy, 0);
    chk("rst done", if_a.done, 0);
    chk("rst pass", if_a.pass, 0);
    chk("rst err_cnt", if_a.err_cnt, 0);
    chk("rst fail_vec", if_a.fail_vec, 0);
    chk("rst fail_valid", if_a.fail_valid, 0);
    chk("rst b busy", if_b.busy, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_a($sformatf("tbl%0d", i), tbl[i].op, tbl[i].tt, tbl[i].poke,
            tbl[i].err, tbl[i].fv, tbl[i].valid);

    for (int r = 0; r < 20; r++) begin
      logic [1:0] op;
      logic [3:0] tt;
      int e_err, e_fv;
      op    = 2'($urandom_range(0, 3));
      tt    = 4'($urandom_range(0, 15));
      e_err = 0;
      e_fv  = -1;
      for (int v = 0; v < 4; v++) begin
        if (tt[v] != ref_f(op, v, 2)) begin
          e_err++;
          if (e_fv < 0) e_fv = v;
        end
      end
      run_a($sformatf("rnd%0d", r), op, tt, 1'b0, e_err, (e_fv < 0) ? 0 : e_fv, (e_err != 0));
    end

    // Reset in the middle of a failing run must wipe all partial results.
    tt_a = 4'b0000;
    @(negedge clk);
    if_a.op    = 2'b00;
    if_a.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if_a.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-rst vec", if_a.vec, 2);
    chk("pre-rst err_cnt", if_a.err_cnt, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid-rst vec", if_a.vec, 0);
    chk("mid-rst busy", if_a.busy, 0);
    chk("mid-rst err_cnt", if_a.err_cnt, 0);
    chk("mid-rst pass", if_a.pass, 0);
    chk("mid-rst fail_valid", if_a.fail_valid, 0);
    begin
      int stray = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (if_a.done !== 1'b0 || if_a.busy !== 1'b0) stray++;
      end
      chk("post-rst no done", stray, 0);
    end
    run_a("post-rst", 2'b00, 4'b1110, 1'b0, 0, 0, 1'b0);

    // Lagging gate: SETTLE=3 hides the delay; SETTLE=1 samples the previous vector's output.
    c_err = 0;
    c_fv  = -1;
    for (int v = 0; v < 8; v++) begin
      bit seen;
      seen = (v == 0) ? 1'b0 : ((v - 1) != 0);
      if (seen != ref_f(2'b00, v, 3)) begin
        c_err++;
        if (c_fv < 0) c_fv = v;
      end
    end
    b_done = -1;
    c_done = -1;
    @(negedge clk);
    if_b.start = 1'b1;
    if_c.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (if_b.done === 1'b1 && b_done < 0) b_done = k;
      if (if_c.done === 1'b1 && c_done < 0) c_done = k;
      if (k == 1) begin
        if_b.start = 1'b0;
        if_c.start = 1'b0;
      end
    end
    chk("b done_at", b_done, 33);
    chk("b pass", if_b.pass, 1);
    chk("b err_cnt", if_b.err_cnt, 0);
    chk("c done_at", c_done, 17);
    chk("c pass", if_c.pass, 0);
    chk("c err_cnt", if_c.err_cnt, c_err);
    chk("c fail_vec", if_c.fail_vec, (c_fv < 0) ? 0 : c_fv);
    chk("c fail_valid", if_c.fail_valid, (c_err != 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_resp_checker.md
Name: gate_resp_checker

Overview:
- Synthesizable on-chip checker that exercises an N-input combinational gate.
- Drives every input vector in ascending order, waits a fixed settle time, then samples the gate output and compares it against a reference function.
- Reports error count, first failing vector and pass/fail.
- Sits opposite the gate under test: owns the stimulus side (`vec`) and the response side (`dut_y`). Replaces hand-written $monitor checking for gate-level blocks and doubles as a BIST wrapper.

Parameters:
- `N_IN`, default 2: number of gate inputs; width of `vec`; 2^N_IN vectors per run; legal range 1..8.
- `SETTLE`, default 1: cycles each vector is held before sampling; legal range 1..15.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `start`  in  1: one-cycle run request; honoured only in IDLE.
- `op`  in  2: reference function, latched on accepted start.
  - 00 = OR
  - 01 = AND
  - 10 = XOR
  - 11 = NOR
- `dut_y`  in  1: output of gate under test.
- `vec`  out  N_IN: stimulus to gate under test.
- `busy`  out  1: high from the cycle after accepted start through the last SAMPLE cycle.
- `done`  out  1: one-cycle pulse at end of run.
- `pass`  out  1: 1 when the last completed run had err_cnt == 0; held until the next accepted start.
- `err_cnt`  out  N_IN+1: number of mismatching vectors in the current or last run.
- `fail_vec`  out  N_IN: first mismatching vector of the current or last run.
- `fail_valid`  out  1: `fail_vec` holds a captured mismatch.

Behaviour:
- Reset (`rst_n` == 0 at a rising edge), same values whether idle or mid-run; no partial result survives:
  - state = IDLE
  - `vec` = 0, `busy` = 0, `done` = 0, `pass` = 0
  - `err_cnt` = 0, `fail_vec` = 0, `fail_valid` = 0
  - settle counter = 0, latched op = 00
- States:
  - IDLE: `start` = 1 → APPLY. At that edge:
    - latch `op`; `vec` = 0; settle_cnt = 0
    - `err_cnt` = 0, `fail_valid` = 0, `fail_vec` = 0, `pass` = 0
  - APPLY: `vec` is stable. settle_cnt increments each cycle; when settle_cnt == SETTLE-1 → SAMPLE, and settle_cnt clears. APPLY therefore lasts exactly SETTLE cycles per vector.
  - SAMPLE (one cycle):
    - Compute expected = f(latched op, `vec`).
    - On `dut_y` != expected at the closing edge: `err_cnt` += 1. If `fail_valid` == 0, capture `fail_vec` = `vec` and set `fail_valid` = 1.
    - If `vec` == all-ones → DONE; `vec` holds its value.
    - Otherwise `vec` += 1 → APPLY.
  - DONE (one cycle):
    - `done` = 1, `busy` = 0.
    - `pass` = (`err_cnt` == 0), using the final count including the last SAMPLE.
    - → IDLE. Results hold until the next accepted start.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - Cycle 0 is the edge that accepts `start`. `done` is high during cycle 2^N_IN × (SETTLE+1) + 1 after it.
- `start` while `busy` or in DONE: ignored; no restart, no latch of `op`.
- `op` changes mid-run have no effect.
- `dut_y` is sampled only in SAMPLE. X/Z handling is out of scope for RTL; the bench drives known values.
- `err_cnt` is N_IN+1 bits wide, enough for 2^N_IN errors, so no saturation is needed.
- Reference functions:
  - OR = reduction-or of `vec`
  - AND = reduction-and
  - XOR = reduction-xor
  - NOR = inverted reduction-or

Decomposition:
- Shared package `gate_chk_pkg`:
  - op encodings OP_OR, OP_AND, OP_XOR, OP_NOR (2 bits)
  - state enum IDLE/APPLY/SAMPLE/DONE
  - SETTLE counter width constant (4 bits)
- One natural sub-module: `gate_ref_model`. Purely combinational `op` + `vec` → expected bit. It is reused by the bench scoreboard.
- FSM, counters and result registers stay in the top.

Test Plan:
1. N_IN=2, SETTLE=1, correct OR model on `dut_y`, `op`=00, `start` pulse:
   - `vec` steps 00,01,10,11, each held 2 cycles.
   - `done` pulse 9 cycles after start.
   - `pass`=1, `err_cnt`=0, `fail_valid`=0.
2. Same setup with `dut_y` stuck at 0:
   - `err_cnt`=3, `fail_vec`=01, `fail_valid`=1, `pass`=0.
3. OR model on `dut_y` with `op`=01 (AND):
   - mismatches at vectors 01 and 10, so `err_cnt`=2, `fail_vec`=01, `pass`=0.
   - Repeat with `op`=11 (NOR): `err_cnt`=4, `fail_vec`=00.
4. Second `start` pulse while `vec`=10, `busy`=1:
   - the run is not restarted; sequence and results match scenario 1.
   - `op` toggled mid-run also has no effect.
5. `rst_n`=0 for one cycle while `vec`=10 in APPLY:
   - next cycle all outputs at reset values (`vec`=0, `busy`=0, `err_cnt`=0, `pass`=0) and no `done` pulse.
   - A fresh `start` then completes normally.
6. N_IN=3, SETTLE=3, OR model delayed 2 cycles on `dut_y`:
   - `pass`=1, 8 vectors × 4 cycles.
   - `done` 33 cycles after start.
   - With SETTLE=1 instead: `pass`=0 and `err_cnt`>0.
